muldiv_share_ctrl: RTL
======================

Name: muldiv_share_ctrl

Overview:
- Controller that shares one iterative multi-cycle MUL/DIV/FDIV/FSQRT unit between the two cores' Execute stages.
- Arbitrates requests round-robin, sequences the unit (start, wait, capture), and returns the result plus destination tag (int or FP register file) to the owning core.
- Supports per-core flush so killed instructions never write back.
- Sits between each core's EX stage and the shared unit; its busy/stall outputs feed each core's hazard/stall logic.

Parameters:
- XLEN, 32, operand/result width
- OPW, 4, operation-code width passed through to the unit
- TIMEOUT, 64, max cycles in WAIT before abort (must be >= 2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  2  per-core request (bit i = core i)
- req_op  in  2*OPW  per-core op, core i at [i*OPW +: OPW]
- req_a  in  2*XLEN  per-core operand A
- req_b  in  2*XLEN  per-core operand B
- req_rd  in  10  per-core destination register (5 bits each)
- req_fp  in  2  per-core destination is FP regfile
- flush  in  2  per-core kill of the outstanding op
- req_ready  out  2  request accepted this cycle
- resp_valid  out  2  result available for core i
- resp_ready  in  2  core i consumes result
- resp_data  out  XLEN  result (0 on timeout)
- resp_rd  out  5  destination register of result
- resp_fp  out  1  destination is FP regfile
- resp_err  out  1  result came from timeout abort
- unit_start  out  1  one-cycle start pulse to unit
- unit_op  out  OPW  latched op
- unit_a, unit_b  out  XLEN  latched operands
- unit_abort  out  1  one-cycle abort pulse to unit
- unit_done  in  1  unit result valid, single-cycle pulse
- unit_result  in  XLEN  unit result
- busy  out  1  state != IDLE

Behaviour:
- Async reset (rst=0): state=IDLE, rr_ptr=0 (core0 priority), timer=0, kill=0. All outputs 0, including latched op/operands/rd/fp/owner.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - eligible[i] = req_valid[i] & ~flush[i].
  - If both cores are eligible, the winner is core rr_ptr; otherwise the single eligible core wins.
  - req_ready[winner]=1 combinationally in the same cycle.
  - On the clock edge: latch op/a/b/rd/fp/owner, set rr_ptr <= ~winner, kill=0, move to ISSUE.
  - req_ready is never asserted in any other state.
- ISSUE:
  - unit_start=1 for exactly this cycle; timer=0; move to WAIT.
  - unit_done in ISSUE is ignored; the unit must not assert it here.
- WAIT:
  - timer increments each cycle.
  - On unit_done: capture unit_result, resp_err=0. If kill, go to IDLE with no response; else go to RESP.
  - If timer==TIMEOUT-1 and there is no unit_done: unit_abort=1 for one cycle, data=0, resp_err=1. Go to RESP, or to IDLE if kill.
  - unit_done in the same cycle as the timeout: done wins, no abort.
- RESP:
  - resp_valid[owner]=1, held with data/rd/fp/err stable until resp_ready[owner]=1.
  - On that handshake edge, go to IDLE.
  - resp_ready of the non-owner core is ignored.
- Flush:
  - flush[owner] in ISSUE or WAIT sets kill (sticky until IDLE).
  - flush[owner] in RESP drops the response: go to IDLE with no handshake.
  - flush of the non-owner core has no effect.
- Minimum latency: grant at cycle 0, unit_start at cycle 1, earliest unit_done at cycle 2, resp_valid at cycle 3. A new grant is possible the cycle after the RESP handshake.
- Each core holds req_valid and its operands stable until req_ready. A core has at most one outstanding op; cores stall on their own req_valid & ~req_ready, or while awaiting resp.
- unit_a/unit_b/unit_op hold their latched values outside ISSUE.

Decomposition:
- Shared package muldiv_pkg: state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3), op-code constants, XLEN/OPW defaults.
- One sub-module, rr_arbiter2: 2-way round-robin winner select from eligible plus rr_ptr.

Test Plan:
- Single request: core0 op=DIV, a=100, b=7, rd=5, fp=0; unit_done 4 cycles after start with result 14 → req_ready[0] at cycle 0, unit_start at cycle 1, resp_valid[0] with data=14, rd=5, fp=0, err=0; IDLE after resp_ready.
- Simultaneous requests after reset: both req_valid=1 → core0 granted first, core1 granted the cycle after core0's RESP handshake; next simultaneous pair → core0 granted again (pointer alternates).
- Flush in WAIT: core1 granted, flush[1] two cycles later, unit_done with 0xDEAD → no resp_valid; busy falls the cycle after done.
- Timeout with TIMEOUT=8, no unit_done → unit_abort pulse at WAIT cycle 8; resp_valid with data=0, err=1.
- Response backpressure: hold resp_ready[0]=0 for 5 cycles while core1 req_valid=1 → resp fields stable, req_ready[1]=0 throughout; core1 granted the cycle after the handshake.
- Reset mid-WAIT: rst=0 → busy, unit_start, resp_valid all 0 immediately; a late unit_done after release is ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the shared MUL/DIV/FDIV/FSQRT controller.
// Holds the FSM state encoding, op-code values and width defaults.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int OPW_DEF  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] OP_MUL    = 4'd0;
    localparam logic [3:0] OP_MULH   = 4'd1;
    localparam logic [3:0] OP_MULHSU = 4'd2;
    localparam logic [3:0] OP_MULHU  = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_DIVU   = 4'd5;
    localparam logic [3:0] OP_REM    = 4'd6;
    localparam logic [3:0] OP_REMU   = 4'd7;
    localparam logic [3:0] OP_FDIV   = 4'd8;
    localparam logic [3:0] OP_FSQRT  = 4'd9;

    function automatic logic [1:0] core_onehot(input logic core);
        return core ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select.
// Ports: eligible (per core), rr_ptr (tie winner), grant_any, winner.
module rr_arbiter2 (
    input  logic [1:0] eligible,
    input  logic       rr_ptr,
    output logic       grant_any,
    output logic       winner
);

    assign grant_any = |eligible;

    always_comb begin
        winner = 1'b0;
        unique case (1'b1)
            (eligible == 2'b11): winner = rr_ptr;
            (eligible == 2'b10): winner = 1'b1;
            default:             winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/muldiv_share_ctrl.sv
// Shares one iterative MUL/DIV/FDIV/FSQRT unit between two cores' EX stages.
// Ports: per-core req_*/flush/resp_ready in, req_ready/resp_* out; unit_* to
// the shared unit; busy to the cores' hazard logic. rst is async active-low.
module muldiv_share_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int OPW     = OPW_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [2*OPW-1:0]  req_op,
    input  logic [2*XLEN-1:0] req_a,
    input  logic [2*XLEN-1:0] req_b,
    input  logic [9:0]        req_rd,
    input  logic [1:0]        req_fp,
    input  logic [1:0]        flush,
    output logic [1:0]        req_ready,
    output logic [1:0]        resp_valid,
    input  logic [1:0]        resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_fp,
    output logic              resp_err,
    output logic              unit_start,
    output logic [OPW-1:0]    unit_op,
    output logic [XLEN-1:0]   unit_a,
    output logic [XLEN-1:0]   unit_b,
    output logic              unit_abort,
    input  logic              unit_done,
    input  logic [XLEN-1:0]   unit_result,
    output logic              busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic            rr_ptr;
    logic            owner;
    logic            kill;
    logic [TW-1:0]   timer;

    logic [1:0]      eligible;
    logic            grant_any;
    logic            winner;

    logic [OPW-1:0]  win_op;
    logic [XLEN-1:0] win_a;
    logic [XLEN-1:0] win_b;
    logic [4:0]      win_rd;
    logic            win_fp;

    logic            flush_own;
    logic            kill_eff;
    logic            timeout_hit;

    assign eligible = req_valid & ~flush;

    rr_arbiter2 u_arb (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant_any (grant_any),
        .winner    (winner)
    );

    assign win_op = winner ? req_op[2*OPW-1 -: OPW]  : req_op[OPW-1:0];
    assign win_a  = winner ? req_a[2*XLEN-1 -: XLEN] : req_a[XLEN-1:0];
    assign win_b  = winner ? req_b[2*XLEN-1 -: XLEN] : req_b[XLEN-1:0];
    assign win_rd = winner ? req_rd[9:5]             : req_rd[4:0];
    assign win_fp = winner ? req_fp[1]               : req_fp[0];

    // A flush arriving in the same cycle as done/timeout still kills the op.
    assign flush_own   = flush[owner];
    assign kill_eff    = kill | flush_own;
    assign timeout_hit = (timer == TW'(TIMEOUT - 1));

    // Grant is combinational; gated by rst so nothing is granted in reset.
    assign req_ready = (rst && state == S_IDLE && grant_any)
                     ? core_onehot(winner) : 2'b00;

    assign busy       = (state != S_IDLE);
    assign unit_start = (state == S_ISSUE);
    assign resp_valid = (state == S_RESP) ? core_onehot(owner) : 2'b00;

    // Done in the timeout cycle wins, so abort only fires without done.
    assign unit_abort = (state == S_WAIT) & timeout_hit & ~unit_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            kill      <= 1'b0;
            timer     <= '0;
            unit_op   <= '0;
            unit_a    <= '0;
            unit_b    <= '0;
            resp_rd   <= '0;
            resp_fp   <= 1'b0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        unit_op <= win_op;
                        unit_a  <= win_a;
                        unit_b  <= win_b;
                        resp_rd <= win_rd;
                        resp_fp <= win_fp;
                        owner   <= winner;
                        rr_ptr  <= ~winner;
                        kill    <= 1'b0;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    kill  <= kill_eff;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    kill  <= kill_eff;
                    if (unit_done || timeout_hit) begin
                        resp_data <= unit_done ? unit_result : '0;
                        resp_err  <= ~unit_done;
                        state     <= kill_eff ? S_IDLE : S_RESP;
                    end
                end
                S_RESP: begin
                    if (flush_own || resp_ready[owner]) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
